// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port RAM with a registered read port
//
// Purpose: storage for sync_fifo_core. One write port and one read port on
// the same clock. The read register only loads when i_rd_en is high and
// otherwise holds its last value.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset (clears the read register only)
//   i_clr     in   synchronous clear of the read register
//   i_wr_en   in   write enable
//   i_wr_addr in   write address
//   i_wr_data in   write data
//   i_rd_en   in   read enable
//   i_rd_addr in   read address
//   o_q       out  registered read data
module sync_fifo_ram #(
  parameter int WIDTH  = 16,
  parameter int WIDTHU = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic [WIDTHU-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [WIDTHU-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_q
);

  localparam int LP_DEPTH = 2 ** WIDTHU;

  logic [WIDTH-1:0] r_mem [LP_DEPTH];
  logic [WIDTH-1:0] r_q;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_rd_en) begin
      r_q <= r_mem[i_rd_addr];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sync_fifo_core.sv
// rtl/sync_fifo_core.sv - single-clock FIFO with flags and registered read port
//
// Purpose: FIFO primitive for latency-insensitive channel shells. Read data
// appears on q one cycle after an accepted rdreq (non-showahead).
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   sclr         in   synchronous clear; overrides wrreq/rdreq that cycle
//   data         in   write data
//   wrreq        in   write request (dropped while full)
//   rdreq        in   read request (ignored while empty)
//   q            out  registered read data, holds when no read is accepted
//   full         out  count == NUMWORDS
//   empty        out  count == 0
//   almost_full  out  count >= ALMOST_FULL_VALUE
//   almost_empty out  count <  ALMOST_EMPTY_VALUE
//   usedw        out  count modulo 2**WIDTHU (reads 0 when full)
module sync_fifo_core #(
  parameter int WIDTH              = 16,
  parameter int WIDTHU             = 1,
  parameter int NUMWORDS           = 2,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter int ALMOST_EMPTY_VALUE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclr,
  input  logic [WIDTH-1:0]  data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [WIDTH-1:0]  q,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [WIDTHU-1:0] usedw
);

  generate
    if (NUMWORDS != 2 ** WIDTHU) begin : g_err_numwords
      $error("sync_fifo_core: NUMWORDS must equal 2**WIDTHU");
    end
    if (ALMOST_FULL_VALUE > NUMWORDS) begin : g_err_af
      $error("sync_fifo_core: ALMOST_FULL_VALUE exceeds NUMWORDS");
    end
    if (ALMOST_EMPTY_VALUE > NUMWORDS) begin : g_err_ae
      $error("sync_fifo_core: ALMOST_EMPTY_VALUE exceeds NUMWORDS");
    end
  endgenerate

  localparam logic [WIDTHU:0]   LP_NUMWORDS = (WIDTHU + 1)'(NUMWORDS);
  localparam logic [WIDTHU:0]   LP_AF       = (WIDTHU + 1)'(ALMOST_FULL_VALUE);
  localparam logic [WIDTHU:0]   LP_AE       = (WIDTHU + 1)'(ALMOST_EMPTY_VALUE);
  localparam logic [WIDTHU:0]   LP_CNT_ONE  = (WIDTHU + 1)'(1);
  localparam logic [WIDTHU-1:0] LP_PTR_ONE  = WIDTHU'(1);

  logic [WIDTHU-1:0] r_wr_ptr;
  logic [WIDTHU-1:0] r_rd_ptr;
  logic [WIDTHU:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  assign w_full  = (r_count == LP_NUMWORDS);
  assign w_empty = (r_count == '0);

  // Gate on the pre-edge flags: a write while full is dropped even if a read
  // frees a slot in the same cycle. sclr suppresses both.
  assign w_wr_en = wrreq & ~w_full  & ~sclr;
  assign w_rd_en = rdreq & ~w_empty & ~sclr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_ram #(
    .WIDTH  (WIDTH),
    .WIDTHU (WIDTHU)
  ) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (sclr),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_q       (q)
  );

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count < LP_AE);
  assign usedw        = r_count[WIDTHU-1:0];

endmodule

// File: tb/tb_sync_fifo_core.sv
// tb/tb_sync_fifo_core.sv - self-checking bench for sync_fifo_core
module tb_sync_fifo_core;

  localparam int WIDTH  = 16;
  localparam int WIDTHU = 2;
  localparam int DEPTH  = 4;
  localparam int AFV    = 3;
  localparam int AEV    = 1;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              sclr    = 1'b0;
  logic              wrreq   = 1'b0;
  logic              rdreq   = 1'b0;
  logic [WIDTH-1:0]  data    = '0;
  logic [WIDTH-1:0]  q;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [WIDTHU-1:0] usedw;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: contents as a queue, plus the last word handed out.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_q = '0;

  sync_fifo_core #(
    .WIDTH              (WIDTH),
    .WIDTHU             (WIDTHU),
    .NUMWORDS           (DEPTH),
    .ALMOST_FULL_VALUE  (AFV),
    .ALMOST_EMPTY_VALUE (AEV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sclr         (sclr),
    .data         (data),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .q            (q),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .usedw        (usedw)
  );

  always #5 clk = ~clk;

  // One clock: drive requests, take the edge, advance the model, settle.
  task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic s);
    bit do_rd;
    bit do_wr;
    wrreq = w;
    rdreq = r;
    data  = d;
    sclr  = s;
    @(posedge clk);
    if (s) begin
      mq.delete();
      m_q = '0;
    end else begin
      do_rd = r && (mq.size() > 0);
      do_wr = w && (mq.size() < DEPTH);
      if (do_rd) m_q = mq.pop_front();
      if (do_wr) mq.push_back(d);
    end
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 16'h1234, 1'b0);
    cyc(1'b1, 1'b0, 16'h5678, 1'b0);
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h1234) $display("FAIL reset_pre_q got %h exp %h", q, 16'h1234); else n_pass++;
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else n_pass++;
    n_checks++; if (usedw !== 2'd0) $display("FAIL reset_usedw got %0d exp 0", usedw); else n_pass++;
    n_checks++; if (q !== 16'h0000) $display("FAIL reset_q got %h exp 0000", q); else n_pass++;
    n_checks++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", almost_full); else n_pass++;
    n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", almost_empty); else n_pass++;
    mq.delete();
    m_q = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] vals [4];
    logic [1:0]       exp_uw [4];
    logic             exp_af [4];
    logic             exp_fl [4];
    vals   = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    exp_uw = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_af = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_fl = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, vals[i], 1'b0);
      n_checks++; if (usedw !== exp_uw[i]) $display("FAIL fill_usedw[%0d] got %0d exp %0d", i, usedw, exp_uw[i]); else n_pass++;
      n_checks++; if (almost_full !== exp_af[i]) $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, exp_af[i]); else n_pass++;
      n_checks++; if (full !== exp_fl[i]) $display("FAIL fill_full[%0d] got %b exp %b", i, full, exp_fl[i]); else n_pass++;
    end
    cyc(1'b1, 1'b0, 16'hDEAD, 1'b0);
    n_checks++; if (full !== 1'b1) $display("FAIL overfill_full got %b exp 1", full); else n_pass++;
    n_checks++; if (usedw !== 2'd0) $display("FAIL overfill_usedw got %0d exp 0", usedw); else n_pass++;
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] vals [4];
    vals = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 16'h0000, 1'b0);
      n_checks++; if (q !== vals[i]) $display("FAIL drain_q[%0d] got %h exp %h", i, q, vals[i]); else n_pass++;
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else n_pass++;
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h0044) $display("FAIL underflow_q got %h exp 0044", q); else n_pass++;
    n_checks++; if (usedw !== 2'd0 || empty !== 1'b1) $display("FAIL underflow_flags got usedw=%0d empty=%b exp usedw=0 empty=1", usedw, empty); else n_pass++;
  endtask

  task automatic test_simultaneous();
    cyc(1'b1, 1'b0, 16'h000A, 1'b0);
    cyc(1'b1, 1'b0, 16'h000B, 1'b0);
    cyc(1'b1, 1'b1, 16'h000C, 1'b0);
    n_checks++; if (q !== 16'h000A) $display("FAIL rw_q got %h exp 000a", q); else n_pass++;
    n_checks++; if (usedw !== 2'd2) $display("FAIL rw_usedw got %0d exp 2", usedw); else n_pass++;
    cyc(1'b1, 1'b0, 16'h000D, 1'b0);
    cyc(1'b1, 1'b0, 16'h000E, 1'b0);
    n_checks++; if (full !== 1'b1) $display("FAIL rw_prefull got %b exp 1", full); else n_pass++;
    cyc(1'b1, 1'b1, 16'h000F, 1'b0);
    n_checks++; if (usedw !== 2'd3 || full !== 1'b0) $display("FAIL rw_full_usedw got usedw=%0d full=%b exp usedw=3 full=0", usedw, full); else n_pass++;
    n_checks++; if (q !== 16'h000B) $display("FAIL rw_full_q got %h exp 000b", q); else n_pass++;
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h000C) $display("FAIL rw_drain0 got %h exp 000c", q); else n_pass++;
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h000D) $display("FAIL rw_drain1 got %h exp 000d", q); else n_pass++;
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h000E) $display("FAIL rw_drain2 got %h exp 000e", q); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rw_dropped_word got empty=%b exp 1", empty); else n_pass++;
    cyc(1'b1, 1'b1, 16'h0077, 1'b0);
    n_checks++; if (q !== 16'h000E) $display("FAIL rw_empty_q got %h exp 000e", q); else n_pass++;
    n_checks++; if (usedw !== 2'd1 || empty !== 1'b0) $display("FAIL rw_empty_usedw got usedw=%0d empty=%b exp usedw=1 empty=0", usedw, empty); else n_pass++;
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h0077) $display("FAIL rw_empty_word got %h exp 0077", q); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < 10; i++) begin
      v = WIDTH'($urandom);
      cyc(1'b1, 1'b0, v, 1'b0);
      cyc(1'b0, 1'b1, 16'h0000, 1'b0);
      n_checks++; if (q !== v || empty !== 1'b1) $display("FAIL wrap[%0d] got q=%h empty=%b exp q=%h empty=1", i, q, empty, v); else n_pass++;
    end
  endtask

  task automatic test_sclr();
    cyc(1'b1, 1'b0, 16'h0101, 1'b0);
    cyc(1'b1, 1'b0, 16'h0202, 1'b0);
    cyc(1'b1, 1'b0, 16'h0303, 1'b0);
    cyc(1'b1, 1'b0, 16'h0404, 1'b0);
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h0101 || usedw !== 2'd3) $display("FAIL sclr_pre got q=%h usedw=%0d exp q=0101 usedw=3", q, usedw); else n_pass++;
    cyc(1'b1, 1'b0, 16'hBEEF, 1'b1);
    n_checks++; if (empty !== 1'b1) $display("FAIL sclr_empty got %b exp 1", empty); else n_pass++;
    n_checks++; if (usedw !== 2'd0) $display("FAIL sclr_usedw got %0d exp 0", usedw); else n_pass++;
    n_checks++; if (q !== 16'h0000) $display("FAIL sclr_q got %h exp 0000", q); else n_pass++;
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    n_checks++; if (q !== 16'h0000 || empty !== 1'b1) $display("FAIL sclr_write_ignored got q=%h empty=%b exp q=0000 empty=1", q, empty); else n_pass++;
  endtask

  task automatic test_random();
    logic             w;
    logic             r;
    logic             s;
    logic [WIDTH-1:0] d;
    int               n;
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 99) < 60);
      r = 1'($urandom_range(0, 99) < 50);
      s = 1'($urandom_range(0, 99) < 2);
      d = WIDTH'($urandom);
      cyc(w, r, d, s);
      n = mq.size();
      n_checks++;
      if (q !== m_q ||
          full !== (n == DEPTH) ||
          empty !== (n == 0) ||
          almost_full !== (n >= AFV) ||
          almost_empty !== (n < AEV) ||
          usedw !== WIDTHU'(n % DEPTH))
        $display("FAIL random[%0d] got q=%h f=%b e=%b af=%b ae=%b uw=%0d exp q=%h count=%0d",
                 i, q, full, empty, almost_full, almost_empty, usedw, m_q, n);
      else
        n_pass++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_sclr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
